cpu_trace_monitor: RTL and testbench

// - Parametrised, synthesisable execution-trace recorder that attaches to the CPU's pc/instruction nets.
// - Runs as a flight recorder: it stores the last DEPTH {cycle, pc, instruction} records in a circular buffer.
// - Stops capture on halt (pc self-loop) or on cycle timeout, then drains the records oldest-first over a valid/ready port.
// - Replaces the fixed-count display loop and fixed-delay finish in the CPU bench with a reusable, self-terminating block.

---
 rtl/cpu_trace_monitor_pkg.sv | 13 +
 rtl/cpu_trace_monitor_if.sv | 22 ++
 rtl/cpu_trace_monitor_ring.sv | 56 +++++
 rtl/cpu_trace_monitor.sv | 98 +++++++++
 tb/tb_cpu_trace_monitor.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_trace_monitor_pkg.sv
// Shared definitions for the execution-trace recorder: FSM encoding and record sizing.
package cpu_trace_monitor_pkg;

  localparam logic [1:0] StRun   = 2'd0;
  localparam logic [1:0] StDrain = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  function automatic int unsigned rec_width(input int unsigned cyc_w, input int unsigned addr_w,
                                            input int unsigned data_w);
    return cyc_w + addr_w + data_w;
  endfunction

endpackage

// File: rtl/cpu_trace_monitor_if.sv
// Drain port of the trace recorder: one {cycle, pc, instruction} record per valid/ready transfer.
interface cpu_trace_monitor_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CYC_W  = 16
);
  logic              trace_valid;
  logic              trace_ready;
  logic [CYC_W-1:0]  trace_cycle;
  logic [ADDR_W-1:0] trace_pc;
  logic [DATA_W-1:0] trace_instr;

  modport master (
    output trace_valid, trace_cycle, trace_pc, trace_instr,
    input  trace_ready
  );

  modport slave (
    input  trace_valid, trace_cycle, trace_pc, trace_instr,
    output trace_ready
  );
endinterface

// File: rtl/cpu_trace_monitor_ring.sv
// Circular record buffer with wrap-bit pointers, overwrite-on-full push and a registered head.
module cpu_trace_monitor_ring #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] PtrOne = {{PTR_W{1'b0}}, 1'b1};

  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] head_q;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                 (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign head  = head_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrOne;
      // A push into a full ring drops the oldest record.
      if (full) rd_ptr_d = rd_ptr_q + PtrOne;
    end else if (pop && !empty) begin
      rd_ptr_d = rd_ptr_q + PtrOne;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[PTR_W-1:0]] <= wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      // Bypass covers a push landing in the slot that becomes the head.
      if (push && (wr_ptr_q[PTR_W-1:0] == rd_ptr_d[PTR_W-1:0])) head_q <= wdata;
      else                                                         head_q <= mem_q[rd_ptr_d[PTR_W-1:0]];
    end
  end
endmodule

// File: rtl/cpu_trace_monitor.sv
// Flight-recorder trace monitor: captures the last DEPTH pc/instruction records, stops on halt
// (pc self-loop) or timeout, then drains oldest-first.
module cpu_trace_monitor
  import cpu_trace_monitor_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned CYC_W       = 16,
  parameter int unsigned HALT_REPEAT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [ADDR_W-1:0] pc,
  input  logic [DATA_W-1:0] instruction,
  input  logic [CYC_W-1:0]  max_cycles,
  cpu_trace_monitor_if.master trace,
  output logic [CYC_W-1:0]  cycle_count,
  output logic              halted,
  output logic              timeout,
  output logic              overflow,
  output logic              done
);
  localparam int unsigned REC_W = rec_width(CYC_W, ADDR_W, DATA_W);
  localparam int unsigned REP_W = $clog2(HALT_REPEAT + 1);

  logic [1:0]        state_q, state_d;
  logic [CYC_W-1:0]  cnt_q, cnt_next;
  logic [REP_W-1:0]  rep_q, rep_next;
  logic [ADDR_W-1:0] prev_pc_q;
  logic              halted_q, timeout_q, overflow_q, done_q;
  logic              capture, hit_halt, hit_to, pop, full, empty;
  logic [REC_W-1:0]  head;

  assign capture  = (state_q == StRun) && enable;
  assign cnt_next = (&cnt_q) ? cnt_q : cnt_q + CYC_W'(1);
  assign rep_next = (pc == prev_pc_q) ? rep_q + REP_W'(1) : REP_W'(1);
  assign hit_halt = capture && (rep_next == REP_W'(HALT_REPEAT));
  assign hit_to   = capture && (max_cycles != '0) && (cnt_next == max_cycles);
  assign pop      = trace.trace_valid && trace.trace_ready;

  cpu_trace_monitor_ring #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_ring (
    .clk   (clk),
    .reset (reset),
    .push  (capture),
    .pop   (pop),
    .wdata ({cnt_q, pc, instruction}),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      StRun:   if (hit_halt || hit_to) state_d = StDrain;
      StDrain: if (empty) state_d = StDone;
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StRun;
      cnt_q      <= '0;
      rep_q      <= '0;
      prev_pc_q  <= '0;
      halted_q   <= 1'b0;
      timeout_q  <= 1'b0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        cnt_q     <= cnt_next;
        rep_q     <= rep_next;
        prev_pc_q <= pc;
      end
      if (hit_halt)                      halted_q   <= 1'b1;
      if (hit_to)                        timeout_q  <= 1'b1;
      if (capture && full)               overflow_q <= 1'b1;
      if ((state_q == StDrain) && empty) done_q     <= 1'b1;
    end
  end

  assign trace.trace_valid = (state_q == StDrain) && !empty;
  assign {trace.trace_cycle, trace.trace_pc, trace.trace_instr} = head;

  assign cycle_count = cnt_q;
  assign halted      = halted_q;
  assign timeout     = timeout_q;
  assign overflow    = overflow_q;
  assign done        = done_q;
endmodule

// File: tb/tb_cpu_trace_monitor.sv
// Self-checking bench for cpu_trace_monitor: directed halt/overflow/timeout/back-pressure cases
// plus randomized capture runs compared against a queue-based reference model.
module tb_cpu_trace_monitor;
  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned DEPTH       = 16;
  localparam int unsigned CYC_W       = 16;
  localparam int unsigned HALT_REPEAT = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              enable = 1'b0;
  logic [ADDR_W-1:0] pc = '0;
  logic [DATA_W-1:0] instruction = '0;
  logic [CYC_W-1:0]  max_cycles = '0;
  logic [CYC_W-1:0]  cycle_count;
  logic              halted, timeout, overflow, done;

  cpu_trace_monitor_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CYC_W(CYC_W)) trace_bus ();

  cpu_trace_monitor #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .DEPTH       (DEPTH),
    .CYC_W       (CYC_W),
    .HALT_REPEAT (HALT_REPEAT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .pc          (pc),
    .instruction (instruction),
    .max_cycles  (max_cycles),
    .trace       (trace_bus),
    .cycle_count (cycle_count),
    .halted      (halted),
    .timeout     (timeout),
    .overflow    (overflow),
    .done        (done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [CYC_W-1:0]  cyc;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } rec_t;

  // Reference model: the recorder is "the last DEPTH samples" of the enabled pc stream.
  rec_t              m_q[$];
  int                m_cnt;
  bit                m_have_prev;
  logic [ADDR_W-1:0] m_prev;
  int                m_rep;
  bit                m_halt, m_to, m_ovf, m_run;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_q.delete();
    m_cnt = 0;
    m_have_prev = 1'b0;
    m_prev = '0;
    m_rep = 0;
    m_halt = 1'b0;
    m_to = 1'b0;
    m_ovf = 1'b0;
    m_run = 1'b1;
  endfunction

  function automatic void model_step(input logic [ADDR_W-1:0] p, input logic [DATA_W-1:0] ins);
    rec_t r;
    if (!m_run) return;
    r.cyc = CYC_W'(m_cnt);
    r.pc = p;
    r.instr = ins;
    m_q.push_back(r);
    if (m_q.size() > DEPTH) begin
      void'(m_q.pop_front());
      m_ovf = 1'b1;
    end
    m_rep = (m_have_prev && p == m_prev) ? m_rep + 1 : 1;
    m_have_prev = 1'b1;
    m_prev = p;
    if (m_cnt < (1 << CYC_W) - 1) m_cnt++;
    if (m_rep >= HALT_REPEAT) m_halt = 1'b1;
    if (max_cycles != 0 && m_cnt == int'(max_cycles)) m_to = 1'b1;
    if (m_halt || m_to) m_run = 1'b0;
  endfunction

  task automatic step(input bit en, input logic [ADDR_W-1:0] p, input logic [DATA_W-1:0] ins);
    @(negedge clk);
    enable = en;
    pc = p;
    instruction = ins;
    if (en) model_step(p, ins);
  endtask

  // Leaves the bench at the first negedge after the final capture edge.
  task automatic idle();
    @(negedge clk);
    enable = 1'b0;
  endtask

  // Mid-cycle reset pulse; outputs must clear before any clock edge.
  task automatic do_reset();
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("rst_valid", trace_bus.trace_valid, 0);
    check("rst_record", {trace_bus.trace_cycle, trace_bus.trace_pc, trace_bus.trace_instr}, 0);
    check("rst_flags", {cycle_count, halted, timeout, overflow, done}, 0);
    #1;
    reset = 1'b1;
    enable = 1'b0;
    trace_bus.trace_ready = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  // mode 0: always ready, 1: ready pattern 1,0,0,1, 2: random ready.
  task automatic drain(input int mode, input int exp_n);
    int k = 0;
    int n_xfer = 0;
    int w = 0;
    bit rdy;
    rec_t front;
    while (m_q.size() > 0 && k < 500) begin
      front = m_q[0];
      check("drain_valid", trace_bus.trace_valid, 1);
      check("drain_data", {trace_bus.trace_cycle, trace_bus.trace_pc, trace_bus.trace_instr}, front);
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (k % 4 == 0) || (k % 4 == 3);
        default: rdy = ($urandom_range(0, 2) != 0);
      endcase
      trace_bus.trace_ready = rdy;
      if (rdy) begin
        void'(m_q.pop_front());
        if (trace_bus.trace_valid) n_xfer++;
      end
      @(negedge clk);
      k++;
    end
    check("drain_budget", m_q.size(), 0);
    check("drain_count", n_xfer, exp_n);
    check("drain_empty_valid", trace_bus.trace_valid, 0);
    while (!done && w < 4) begin
      @(negedge clk);
      w++;
    end
    check("drain_done", done, 1);
    check("done_valid", trace_bus.trace_valid, 0);
    trace_bus.trace_ready = 1'b0;
  endtask

  task automatic halt_seq();
    logic [ADDR_W-1:0] pcs [6];
    pcs = '{32'h0, 32'h4, 32'h8, 32'hC, 32'hC, 32'hC};
    for (int i = 0; i < 6; i++) step(1'b1, pcs[i], $urandom);
    idle();
  endtask

  initial begin
    trace_bus.trace_ready = 1'b0;
    model_reset();
    do_reset();

    // Halt on self-loop, no timeout.
    max_cycles = '0;
    halt_seq();
    check("halt_flags", {halted, timeout, overflow}, 3'b100);
    check("halt_count", cycle_count, 6);
    check("halt_first_cycle", trace_bus.trace_cycle, 0);
    drain(0, 6);

    // Overflow: 20 distinct pcs, then two repeats of the last one.
    do_reset();
    for (int i = 0; i < 20; i++) step(1'b1, ADDR_W'(32'h100 + 4 * i), $urandom);
    step(1'b1, ADDR_W'(32'h100 + 4 * 19), $urandom);
    step(1'b1, ADDR_W'(32'h100 + 4 * 19), $urandom);
    idle();
    check("ovf_flags", {halted, timeout, overflow}, 3'b101);
    check("ovf_first_cycle", trace_bus.trace_cycle, 6);
    drain(0, 16);

    // Timeout with back-pressure pattern.
    do_reset();
    max_cycles = 5;
    for (int i = 0; i < 20 && m_run; i++) step(1'b1, ADDR_W'(4 * i), $urandom);
    idle();
    check("to_flags", {halted, timeout, overflow}, 3'b010);
    check("to_count", cycle_count, 5);
    drain(1, 5);

    // Halt and timeout on the same edge.
    do_reset();
    max_cycles = 6;
    halt_seq();
    check("both_flags", {halted, timeout}, 2'b11);
    check("both_drain_state", trace_bus.trace_valid, 1);
    drain(2, 6);

    // Reset mid-drain discards everything.
    do_reset();
    max_cycles = '0;
    halt_seq();
    trace_bus.trace_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    do_reset();
    @(negedge clk);
    check("post_rst_valid", {trace_bus.trace_valid, done, halted}, 3'b000);

    // Randomized runs against the model.
    for (int run = 0; run < 8; run++) begin
      logic [ADDR_W-1:0] lastp;
      logic [ADDR_W-1:0] p;
      bit en;
      do_reset();
      max_cycles = CYC_W'($urandom_range(0, 40));
      lastp = '0;
      for (int i = 0; i < 60 && m_run; i++) begin
        en = ($urandom_range(0, 3) != 0);
        p = ($urandom_range(0, 2) == 0) ? lastp : ADDR_W'(4 * $urandom_range(0, 7));
        if (en) lastp = p;
        step(en, p, $urandom);
      end
      for (int i = 0; i < 10 && m_run; i++) step(1'b1, lastp, $urandom);
      idle();
      check("rnd_flags", {halted, timeout, overflow}, {m_halt, m_to, m_ovf});
      check("rnd_count", cycle_count, m_cnt);
      drain(2, m_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
